// File: rtl/spi_dbg_pkg.sv
// spi_dbg_pkg: shared definitions for the SPI debug command sequencer.
//   - opcode constants (word[31:28]) OP_NOP .. OP_CLRERR
//   - FSM state encoding (2 bits, also reported in the status word)
//   - STATUS_MAGIC, the tag byte at the top of every status word
//   - clog2 helper used to size the optional timeout counter
package spi_dbg_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_WIMEM  = 4'h1;
    localparam logic [3:0] OP_RREG   = 4'h2;
    localparam logic [3:0] OP_STEP   = 4'h3;
    localparam logic [3:0] OP_RUN    = 4'h4;
    localparam logic [3:0] OP_HALT   = 4'h5;
    localparam logic [3:0] OP_RPC    = 4'h6;
    localparam logic [3:0] OP_CLRERR = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GET_ADDR = 2'd1,
        ST_GET_DATA = 2'd2,
        ST_RD_WAIT  = 2'd3
    } state_e;

    localparam logic [7:0] STATUS_MAGIC = 8'hA5;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/spi_dbg_ctrl_if.sv
// spi_dbg_ctrl_if: bundles the SPI-side, instruction-memory, register-read
// and core-control signals of spi_dbg_ctrl.
//   slave  modport: the sequencer (takes i_*, drives o_*)
//   master modport: the surroundings (SPI slave, imem, register file, core)
interface spi_dbg_ctrl_if #(
    parameter int NB_BITS    = 32,
    parameter int NB_ADDR    = 10,
    parameter int NB_REG_IDX = 5
) ();
    logic                  i_cs;
    logic [NB_BITS-1:0]    i_rx_data;
    logic [NB_BITS-1:0]    o_tx_data;
    logic                  o_imem_we;
    logic [NB_ADDR-1:0]    o_imem_addr;
    logic [NB_BITS-1:0]    o_imem_data;
    logic                  o_rd_req;
    logic [NB_REG_IDX:0]   o_rd_sel;
    logic                  i_rd_ack;
    logic [NB_BITS-1:0]    i_rd_data;
    logic                  o_run;
    logic                  o_step;
    logic                  o_err;

    modport slave (
        input  i_cs, i_rx_data, i_rd_ack, i_rd_data,
        output o_tx_data, o_imem_we, o_imem_addr, o_imem_data,
               o_rd_req, o_rd_sel, o_run, o_step, o_err
    );

    modport master (
        output i_cs, i_rx_data, i_rd_ack, i_rd_data,
        input  o_tx_data, o_imem_we, o_imem_addr, o_imem_data,
               o_rd_req, o_rd_sel, o_run, o_step, o_err
    );
endinterface

// File: rtl/spi_cs_sync.sv
// spi_cs_sync: brings the asynchronous SPI chip select into the i_clk domain
// and flags the end of each SPI word.
//   i_clk, i_rst : clock, asynchronous active-low reset
//   i_cs         : raw chip select (active-high)
//   o_wv         : one-cycle pulse on the 1->0 edge of the synchronised cs
module spi_cs_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_cs,
    output logic o_wv
);
    logic cs_meta_q, cs_meta_d;
    logic cs_sync_q, cs_sync_d;
    logic cs_prev_q, cs_prev_d;

    always_comb begin
        cs_meta_d = i_cs;
        cs_sync_d = cs_meta_q;
        cs_prev_d = cs_sync_q;
    end

    // NOTE: flops use non-blocking assignments so every stage samples the
    // previous stage's old value; blocking here would collapse the chain.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cs_meta_q <= 1'b0;
            cs_sync_q <= 1'b0;
            cs_prev_q <= 1'b0;
        end else begin
            cs_meta_q <= cs_meta_d;
            cs_sync_q <= cs_sync_d;
            cs_prev_q <= cs_prev_d;
        end
    end

    assign o_wv = cs_prev_q & ~cs_sync_q;
endmodule

// File: rtl/spi_dbg_ctrl.sv
// spi_dbg_ctrl: debug command sequencer behind the 32-bit SPI slave.
// Decodes each received word, sequences imem writes, register/PC reads and
// run/step/halt, and chooses the word the slave shifts out next
// (held read data, otherwise the live status word).
//   i_clk, i_rst : clock, asynchronous active-low reset
//   bus (slave)  : SPI cs/rx/tx, imem write port, read req/ack, run/step/err
// Optional build macro: SPI_DBG_TIMEOUT_EN adds an inter-word timeout that
// abandons a half-received WIMEM after TIMEOUT_CYCLES cycles.
module spi_dbg_ctrl
    import spi_dbg_pkg::*;
#(
    parameter int NB_BITS        = 32,
    parameter int NB_ADDR        = 10,
    parameter int NB_REG_IDX     = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic           i_clk,
    input logic           i_rst,
    spi_dbg_ctrl_if.slave bus
);
    logic               wv;
    logic [NB_BITS-1:0] word;
    logic [3:0]         op;

    state_e              state_q, state_d;
    logic                run_q, run_d;
    logic                err_q, err_d;
    logic                step_q, step_d;
    logic                we_q, we_d;
    logic [NB_ADDR-1:0]  addr_q, addr_d;
    logic [NB_BITS-1:0]  data_q, data_d;
    logic                rd_req_q, rd_req_d;
    logic [NB_REG_IDX:0] rd_sel_q, rd_sel_d;
    logic [NB_BITS-1:0]  tx_data_q, tx_data_d;
    logic                tx_hold_q, tx_hold_d;
    logic                tmo_hit;

    spi_cs_sync u_cs_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_cs  (bus.i_cs),
        .o_wv  (wv)
    );

    // The slave has already latched the word by the time wv fires, so it is
    // consumed straight from the port in the wv cycle.
    assign word = bus.i_rx_data;
    assign op   = word[31:28];

`ifdef SPI_DBG_TIMEOUT_EN
    localparam int TMO_W = clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             waiting;

    assign waiting = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);

    always_comb begin
        tmo_d = '0;
        if (waiting && !wv) tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end

    // A word arriving in the same cycle wins over the timeout.
    assign tmo_hit = waiting && !wv && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // NOTE: every signal gets its hold/default value before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        err_d     = err_q;
        step_d    = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        rd_req_d  = rd_req_q;
        rd_sel_d  = rd_sel_q;
        tx_data_d = tx_data_q;
        tx_hold_d = tx_hold_q & ~wv;   // read data is shifted out once only

        unique case (state_q)
            ST_IDLE: if (wv) begin
                unique case (op)
                    OP_NOP:   ;
                    OP_WIMEM: state_d = ST_GET_ADDR;
                    OP_RREG: begin
                        state_d  = ST_RD_WAIT;
                        rd_req_d = 1'b1;
                        rd_sel_d = {1'b0, word[NB_REG_IDX-1:0]};
                    end
                    OP_RPC: begin
                        state_d  = ST_RD_WAIT;
                        rd_req_d = 1'b1;
                        rd_sel_d = {1'b1, {NB_REG_IDX{1'b0}}};
                    end
                    OP_STEP: begin
                        if (!run_q) step_d = 1'b1;
                        else        err_d  = 1'b1;
                    end
                    OP_RUN:    run_d = 1'b1;
                    OP_HALT:   run_d = 1'b0;
                    OP_CLRERR: err_d = 1'b0;
                    default:   err_d = 1'b1;
                endcase
            end
            ST_GET_ADDR: begin
                if (tmo_hit) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (wv) begin
                    addr_d  = word[NB_ADDR-1:0];
                    state_d = ST_GET_DATA;
                end
            end
            ST_GET_DATA: begin
                if (tmo_hit) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (wv) begin
                    data_d  = word;
                    we_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (bus.i_rd_ack) begin
                    tx_data_d = bus.i_rd_data;
                    tx_hold_d = 1'b1;
                    rd_req_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
                // Words cannot be queued behind a pending read.
                if (wv) err_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            err_q     <= 1'b0;
            step_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_req_q  <= 1'b0;
            rd_sel_q  <= '0;
            tx_data_q <= '0;
            tx_hold_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            err_q     <= err_d;
            step_q    <= step_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_req_q  <= rd_req_d;
            rd_sel_q  <= rd_sel_d;
            tx_data_q <= tx_data_d;
            tx_hold_q <= tx_hold_d;
        end
    end

    assign bus.o_tx_data   = tx_hold_q ? tx_data_q
                           : NB_BITS'({STATUS_MAGIC, 20'h0, err_q, run_q, state_q});
    assign bus.o_imem_we   = we_q;
    assign bus.o_imem_addr = addr_q;
    assign bus.o_imem_data = data_q;
    assign bus.o_rd_req    = rd_req_q;
    assign bus.o_rd_sel    = rd_sel_q;
    assign bus.o_run       = run_q;
    assign bus.o_step      = step_q;
    assign bus.o_err       = err_q;
endmodule

// File: tb/tb_spi_dbg_ctrl.sv
// tb_spi_dbg_ctrl: self-checking bench for spi_dbg_ctrl. Directed scenarios
// followed by a randomized command stream, checked against a command-level
// model (run/err flags, protocol phase, pending read data, pulse counts).
module tb_spi_dbg_ctrl;
    localparam int NB_BITS        = 32;
    localparam int NB_ADDR        = 10;
    localparam int NB_REG_IDX     = 5;
    localparam int TIMEOUT_CYCLES = 64;

    // Protocol phases as reported in the status word.
    localparam logic [1:0] P_IDLE = 2'd0, P_ADDR = 2'd1, P_DATA = 2'd2, P_READ = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_dbg_ctrl_if #(.NB_BITS(NB_BITS), .NB_ADDR(NB_ADDR), .NB_REG_IDX(NB_REG_IDX)) bus ();

    spi_dbg_ctrl #(
        .NB_BITS(NB_BITS), .NB_ADDR(NB_ADDR), .NB_REG_IDX(NB_REG_IDX),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Model state
    logic        m_run = 1'b0, m_err = 1'b0;
    logic [1:0]  m_phase = P_IDLE;
    logic        m_hold = 1'b0;
    logic [31:0] m_hold_data = '0;
    int          exp_we = 0, exp_step = 0;

    // Pulse monitor
    int          we_cnt = 0, step_cnt = 0;
    logic [9:0]  last_addr = '0;
    logic [31:0] last_data = '0;

    always @(negedge clk) begin
        if (bus.o_imem_we) begin
            we_cnt++;
            last_addr = bus.o_imem_addr;
            last_data = bus.o_imem_data;
        end
        if (bus.o_step) step_cnt++;
    end

    function automatic logic [31:0] exp_status();
        return {8'hA5, 20'h0, m_err, m_run, m_phase};
    endfunction

    // One SPI transaction: the slave loads o_tx_data when cs rises, and the
    // received word is visible on i_rx_data before cs falls.
    task automatic xfer(input logic [31:0] word);
        logic [31:0] exp;
        @(posedge clk); #1;
        bus.i_cs = 1'b1;
        exp = m_hold ? m_hold_data : exp_status();
        vectors++;
        if (bus.o_tx_data !== exp) begin
            miscompares++;
            $display("FAIL shift_out word=%h got=%h exp=%h", word, bus.o_tx_data, exp);
        end
        m_hold = 1'b0;
        repeat (3) @(posedge clk); #1;
        bus.i_rx_data = word;
        bus.i_cs = 1'b0;
        repeat (4) @(posedge clk); #1;
    endtask

    task automatic check_flags(input string tag);
        vectors++;
        if (bus.o_run !== m_run || bus.o_err !== m_err) begin
            miscompares++;
            $display("FAIL %s run/err got=%b%b exp=%b%b", tag, bus.o_run, bus.o_err, m_run, m_err);
        end
        vectors++;
        if (step_cnt != exp_step || we_cnt != exp_we) begin
            miscompares++;
            $display("FAIL %s step/we count got=%0d/%0d exp=%0d/%0d", tag, step_cnt, we_cnt, exp_step, exp_we);
        end
    endtask

    // Single-word commands (everything except WIMEM/RREG/RPC).
    task automatic cmd_simple(input logic [31:0] word);
        xfer(word);
        case (word[31:28])
            4'h0: ;
            4'h3: if (!m_run) exp_step++; else m_err = 1'b1;
            4'h4: m_run = 1'b1;
            4'h5: m_run = 1'b0;
            4'hE: m_err = 1'b0;
            default: m_err = 1'b1;
        endcase
        check_flags("simple");
    endtask

    task automatic cmd_wimem(input logic [31:0] addr_word, input logic [31:0] data);
        xfer({4'h1, 28'($urandom)});
        m_phase = P_ADDR;
        xfer(addr_word);
        m_phase = P_DATA;
        xfer(data);
        m_phase = P_IDLE;
        exp_we++;
        check_flags("wimem");
        vectors++;
        if (last_addr !== addr_word[9:0] || last_data !== data) begin
            miscompares++;
            $display("FAIL wimem addr/data got=%h/%h exp=%h/%h", last_addr, last_data, addr_word[9:0], data);
        end
    endtask

    task automatic cmd_read(input bit is_pc, input logic [4:0] idx,
                            input logic [31:0] data, input int delay);
        logic [31:0] word;
        logic [5:0]  exp_sel;
        word    = is_pc ? {4'h6, 28'($urandom)} : {4'h2, 23'($urandom), idx};
        exp_sel = is_pc ? 6'b100000 : {1'b0, idx};
        xfer(word);
        m_phase = P_READ;
        vectors++;
        if (bus.o_rd_req !== 1'b1 || bus.o_rd_sel !== exp_sel) begin
            miscompares++;
            $display("FAIL rd_req/sel got=%b/%h exp=1/%h", bus.o_rd_req, bus.o_rd_sel, exp_sel);
        end
        repeat (delay) @(posedge clk);
        #1;
        vectors++;
        if (bus.o_rd_req !== 1'b1 || bus.o_rd_sel !== exp_sel) begin
            miscompares++;
            $display("FAIL rd_hold got=%b/%h exp=1/%h", bus.o_rd_req, bus.o_rd_sel, exp_sel);
        end
        bus.i_rd_ack  = 1'b1;
        bus.i_rd_data = data;
        @(posedge clk); #1;
        bus.i_rd_ack  = 1'b0;
        bus.i_rd_data = $urandom;
        m_phase = P_IDLE;
        m_hold = 1'b1;
        m_hold_data = data;
        vectors++;
        if (bus.o_rd_req !== 1'b0 || bus.o_tx_data !== data) begin
            miscompares++;
            $display("FAIL rd_ack req/tx got=%b/%h exp=0/%h", bus.o_rd_req, bus.o_tx_data, data);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.o_tx_data !== 32'hA500_0000 || bus.o_run !== 1'b0 || bus.o_err !== 1'b0 ||
            bus.o_imem_we !== 1'b0 || bus.o_step !== 1'b0 || bus.o_rd_req !== 1'b0 ||
            bus.o_imem_addr !== '0 || bus.o_imem_data !== '0 || bus.o_rd_sel !== '0) begin
            miscompares++;
            $display("FAIL reset_values tx=%h run=%b err=%b we=%b step=%b req=%b addr=%h data=%h sel=%h exp tx=a5000000 rest=0",
                     bus.o_tx_data, bus.o_run, bus.o_err, bus.o_imem_we, bus.o_step,
                     bus.o_rd_req, bus.o_imem_addr, bus.o_imem_data, bus.o_rd_sel);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_wimem();
        cmd_wimem(32'h0000_0004, 32'hDEAD_BEEF);
    endtask

    task automatic test_rreg();
        cmd_read(1'b0, 5'd3, 32'h1234_5678, 5);
        cmd_simple(32'h0000_0000);   // shifts out the read data
        cmd_simple(32'h0000_0000);   // shifts out status again
    endtask

    task automatic test_run_step_halt();
        cmd_simple(32'h4000_0000);
        cmd_simple(32'h3000_0000);
        cmd_simple(32'h5000_0000);
        cmd_simple(32'h3000_0000);
        cmd_simple(32'hE000_0000);
    endtask

    task automatic test_bad_op();
        cmd_simple(32'h9000_0000);
        vectors++;
        if (bus.o_tx_data !== 32'hA500_0008) begin
            miscompares++;
            $display("FAIL bad_op status got=%h exp=a5000008", bus.o_tx_data);
        end
        cmd_simple(32'hE000_0000);
    endtask

    task automatic test_rd_drop();
        xfer(32'h2000_0007);
        m_phase = P_READ;
        xfer(32'h4000_0000);          // dropped while the read is pending
        m_err = 1'b1;
        check_flags("rd_drop");
        vectors++;
        if (bus.o_rd_req !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_drop pending got=%b exp=1", bus.o_rd_req);
        end
        bus.i_rd_ack = 1'b1;
        bus.i_rd_data = 32'hCAFE_0001;
        @(posedge clk); #1;
        bus.i_rd_ack = 1'b0;
        m_phase = P_IDLE;
        m_hold = 1'b1;
        m_hold_data = 32'hCAFE_0001;
        cmd_simple(32'hE000_0000);
    endtask

    task automatic test_reset_mid();
        int we_before;
        cmd_simple(32'h4000_0000);
        cmd_simple(32'hB000_0000);
        xfer(32'h1000_0000);
        m_phase = P_ADDR;
        xfer(32'h0000_0010);
        m_phase = P_DATA;
        we_before = we_cnt;
        bus.i_rx_data = 32'h5555_AAAA;
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        m_run = 1'b0; m_err = 1'b0; m_phase = P_IDLE; m_hold = 1'b0;
        vectors++;
        if (bus.o_run !== 1'b0 || bus.o_err !== 1'b0 || bus.o_tx_data !== 32'hA500_0000 ||
            bus.o_imem_we !== 1'b0 || bus.o_imem_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_mid run=%b err=%b tx=%h we=%b addr=%h exp 0/0/a5000000/0/0",
                     bus.o_run, bus.o_err, bus.o_tx_data, bus.o_imem_we, bus.o_imem_addr);
        end
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        repeat (5) @(posedge clk); #1;
        vectors++;
        if (we_cnt != we_before) begin
            miscompares++;
            $display("FAIL reset_mid partial write got=%0d exp=%0d", we_cnt, we_before);
        end
        cmd_wimem(32'h0000_03FF, 32'h0BAD_F00D);
    endtask

`ifdef SPI_DBG_TIMEOUT_EN
    task automatic test_timeout();
        xfer(32'h1000_0000);
        m_phase = P_ADDR;
        repeat (TIMEOUT_CYCLES + 2) @(posedge clk);
        #1;
        m_phase = P_IDLE;
        m_err = 1'b1;
        check_flags("timeout");
        cmd_simple(32'h4000_0000);    // decoded as RUN, not as an address
        cmd_simple(32'hE000_0000);
    endtask
`endif

    task automatic test_random();
        logic [3:0] bad_ops [8];
        bad_ops = '{4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF};
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: cmd_simple({4'h0, 28'($urandom)});
                1: cmd_simple({4'h4, 28'($urandom)});
                2: cmd_simple({4'h5, 28'($urandom)});
                3: cmd_simple({4'h3, 28'($urandom)});
                4: cmd_simple({bad_ops[$urandom_range(0, 7)], 28'($urandom)});
                5: cmd_simple(32'hE000_0000);
                6: cmd_wimem($urandom, $urandom);
                default: cmd_read(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                                  $urandom_range(0, 6));
            endcase
        end
    endtask

    initial begin
        bus.i_cs = 1'b0;
        bus.i_rx_data = '0;
        bus.i_rd_ack = 1'b0;
        bus.i_rd_data = '0;
        test_reset();
        test_wimem();
        test_rreg();
        test_run_step_halt();
        test_bad_op();
        test_rd_drop();
        test_reset_mid();
`ifdef SPI_DBG_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
